// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and constants for the counter and decoder.
// Helpers operate on zero-extended 32-bit words; callers truncate to their width.
package gray_pkg;

  localparam int GRAY_DEFAULT_WIDTH = 4;
  localparam int GRAY_MAX_WIDTH     = 32;

  typedef logic [GRAY_MAX_WIDTH-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits leave the prefix XOR untouched, so any narrower width works.
  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b = g;
    for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Bundle of the gray_counter control, count and decoder signals.
// master drives the stimulus side, slave is the counter's view.
interface gray_counter_if #(
  parameter int WIDTH = gray_pkg::GRAY_DEFAULT_WIDTH
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] bin_out;
  logic [WIDTH-1:0] gray_out;
  logic             tc;
  logic             wrap;
  logic [WIDTH-1:0] gray_in;
  logic             gray_in_vld;
  logic [WIDTH-1:0] bin_dec;
  logic             bin_dec_vld;

  modport master (
    output en, up_dn, load, load_val, gray_in, gray_in_vld,
    input  bin_out, gray_out, tc, wrap, bin_dec, bin_dec_vld
  );

  modport slave (
    input  en, up_dn, load, load_val, gray_in, gray_in_vld,
    output bin_out, gray_out, tc, wrap, bin_dec, bin_dec_vld
  );
endinterface

// File: rtl/gray2bin_reg.sv
// Registered Gray-to-binary decoder, one word per cycle, latency 1, never stalls.
// bin_dec holds its last value while gray_in_vld is low.
module gray2bin_reg
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             gray_in_vld,
  output logic [WIDTH-1:0] bin_dec,
  output logic             bin_dec_vld
);

  logic [WIDTH-1:0] bin_dec_q, bin_dec_d;
  logic             bin_dec_vld_q, bin_dec_vld_d;

  always_comb begin
    bin_dec_d     = bin_dec_q;
    bin_dec_vld_d = gray_in_vld;
    if (gray_in_vld) begin
      bin_dec_d = WIDTH'(gray2bin(GRAY_MAX_WIDTH'(gray_in)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_dec_q     <= '0;
      bin_dec_vld_q <= 1'b0;
    end else begin
      bin_dec_q     <= bin_dec_d;
      bin_dec_vld_q <= bin_dec_vld_d;
    end
  end

  assign bin_dec     = bin_dec_q;
  assign bin_dec_vld = bin_dec_vld_q;

endmodule

// File: rtl/gray_counter.sv
// Up/down binary+Gray counter with load, terminal count, wrap pulse and an independent decoder.
// Define GRAY_CNT_SAT_EN to saturate at the terminal count instead of wrapping.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc,
  output logic             wrap,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             gray_in_vld,
  output logic [WIDTH-1:0] bin_dec,
  output logic             bin_dec_vld
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  // tc looks at the live direction so a direction change is honoured immediately.
  assign tc = up_dn ? (bin_q == ALL_ONES) : (bin_q == '0);

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_val;
    end else if (en) begin
`ifdef GRAY_CNT_SAT_EN
      if (!tc) begin
        bin_d = up_dn ? (bin_q + ONE) : (bin_q - ONE);
      end
`else
      bin_d  = up_dn ? (bin_q + ONE) : (bin_q - ONE);
      wrap_d = tc;
`endif
    end
    gray_d = WIDTH'(bin2gray(GRAY_MAX_WIDTH'(bin_d)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;

  gray2bin_reg #(
    .WIDTH (WIDTH)
  ) u_dec (
    .clk         (clk),
    .rst         (rst),
    .gray_in     (gray_in),
    .gray_in_vld (gray_in_vld),
    .bin_dec     (bin_dec),
    .bin_dec_vld (bin_dec_vld)
  );

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: directed literal checks plus randomized
// traffic compared every cycle against an integer-arithmetic reference model.
module tb_gray_counter;

  localparam int W    = gray_pkg::GRAY_DEFAULT_WIDTH;
  localparam int MAXV = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gray_counter_if #(.WIDTH(W)) bus ();

  gray_counter #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (bus.en),
    .up_dn       (bus.up_dn),
    .load        (bus.load),
    .load_val    (bus.load_val),
    .bin_out     (bus.bin_out),
    .gray_out    (bus.gray_out),
    .tc          (bus.tc),
    .wrap        (bus.wrap),
    .gray_in     (bus.gray_in),
    .gray_in_vld (bus.gray_in_vld),
    .bin_dec     (bus.bin_dec),
    .bin_dec_vld (bus.bin_dec_vld)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Decode by searching the Gray sequence rather than by XOR-prefix.
  function automatic int decode(input int g);
    for (int b = 0; b <= MAXV; b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  // Reference model state
  int m_cnt, m_dec;
  bit m_wrap, m_dvld, m_step, m_valid, m_at_end;

  always @(posedge clk) begin
    m_step = 1'b0;
    if (rst) begin
      m_cnt = 0; m_wrap = 1'b0; m_dec = 0; m_dvld = 1'b0; m_valid = 1'b1;
    end else begin
      if (bus.load) begin
        m_cnt  = int'(bus.load_val);
        m_wrap = 1'b0;
      end else if (bus.en) begin
        m_at_end = bus.up_dn ? (m_cnt == MAXV) : (m_cnt == 0);
`ifdef GRAY_CNT_SAT_EN
        m_wrap = 1'b0;
        if (!m_at_end) begin
          m_cnt  = bus.up_dn ? m_cnt + 1 : m_cnt - 1;
          m_step = 1'b1;
        end
`else
        m_cnt  = (m_cnt + (bus.up_dn ? 1 : MAXV)) % (MAXV + 1);
        m_wrap = m_at_end;
        m_step = 1'b1;
`endif
      end else begin
        m_wrap = 1'b0;
      end
      if (bus.gray_in_vld) m_dec = decode(int'(bus.gray_in));
      m_dvld = bus.gray_in_vld;
    end
  end

  // Compare process: outputs are stable at the falling edge.
  logic [W-1:0] prev_gray;
  always @(negedge clk) begin
    if (m_valid) begin
      chk("bin_out",  32'(bus.bin_out),  32'(m_cnt));
      chk("gray_out", 32'(bus.gray_out), 32'(m_cnt ^ (m_cnt >> 1)));
      chk("tc",       32'(bus.tc),       32'(bus.up_dn ? (m_cnt == MAXV) : (m_cnt == 0)));
      chk("wrap",     32'(bus.wrap),     32'(m_wrap));
      chk("bin_dec_vld", 32'(bus.bin_dec_vld), 32'(m_dvld));
      chk("bin_dec",  32'(bus.bin_dec),  32'(m_dec));
      if (m_step) chk("gray_hamming", 32'($countones(bus.gray_out ^ prev_gray)), 32'd1);
    end
    prev_gray = bus.gray_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.en = 1'b0; bus.up_dn = 1'b0; bus.load = 1'b0; bus.load_val = '0;
    bus.gray_in = '0; bus.gray_in_vld = 1'b0;
    tick(); tick();
    chk("rst_bin", 32'(bus.bin_out), 32'd0);
    chk("rst_gray", 32'(bus.gray_out), 32'd0);
    chk("rst_wrap", 32'(bus.wrap), 32'd0);
    chk("rst_dvld", 32'(bus.bin_dec_vld), 32'd0);
    chk("rst_tc_down", 32'(bus.tc), 32'd1);

    // Count up three steps
    rst = 1'b0; bus.en = 1'b1; bus.up_dn = 1'b1;
    tick(); tick(); tick();
    bus.en = 1'b0;
    chk("up3_bin", 32'(bus.bin_out), 32'd3);
    chk("up3_gray", 32'(bus.gray_out), 32'b0010);
    chk("up3_wrap", 32'(bus.wrap), 32'd0);

    // Down one step from reset
    rst = 1'b1; tick();
    rst = 1'b0; bus.up_dn = 1'b0; bus.en = 1'b1; tick();
    bus.en = 1'b0;
`ifdef GRAY_CNT_SAT_EN
    chk("down_bin", 32'(bus.bin_out), 32'd0);
    chk("down_wrap", 32'(bus.wrap), 32'd0);
`else
    chk("down_bin", 32'(bus.bin_out), 32'd15);
    chk("down_gray", 32'(bus.gray_out), 32'b1000);
    chk("down_wrap", 32'(bus.wrap), 32'd1);
`endif

    // Terminal count going up from 15
    bus.load = 1'b1; bus.load_val = 4'd15; tick();
    bus.load = 1'b0; bus.up_dn = 1'b1; #1;
    chk("tc_at_15", 32'(bus.tc), 32'd1);
    chk("wrap_after_load", 32'(bus.wrap), 32'd0);
`ifdef GRAY_CNT_SAT_EN
    bus.en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_bin", 32'(bus.bin_out), 32'd15);
      chk("sat_wrap", 32'(bus.wrap), 32'd0);
    end
    bus.en = 1'b0;
`else
    bus.en = 1'b1; tick();
    bus.en = 1'b0;
    chk("wrap_bin", 32'(bus.bin_out), 32'd0);
    chk("wrap_gray", 32'(bus.gray_out), 32'd0);
    chk("wrap_pulse", 32'(bus.wrap), 32'd1);
    tick();
    chk("wrap_one_cycle", 32'(bus.wrap), 32'd0);
`endif

    // Load beats enable
    bus.load = 1'b1; bus.load_val = 4'd9; bus.en = 1'b1; tick();
    bus.load = 1'b0; bus.en = 1'b0;
    chk("load_bin", 32'(bus.bin_out), 32'd9);
    chk("load_gray", 32'(bus.gray_out), 32'b1101);

    // Decoder stream, then reset mid-stream
    bus.gray_in_vld = 1'b1;
    bus.gray_in = 4'b1101; tick();
    chk("dec_9", 32'(bus.bin_dec), 32'd9);
    chk("dec_vld", 32'(bus.bin_dec_vld), 32'd1);
    bus.gray_in = 4'b1000; tick();
    chk("dec_15", 32'(bus.bin_dec), 32'd15);
    bus.gray_in = 4'b0010; tick();
    chk("dec_3", 32'(bus.bin_dec), 32'd3);
    rst = 1'b1; bus.gray_in = 4'b0101; tick();
    chk("dec_rst_vld", 32'(bus.bin_dec_vld), 32'd0);
    chk("dec_rst_val", 32'(bus.bin_dec), 32'd0);
    rst = 1'b0; bus.gray_in_vld = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 59) == 0);
      bus.load        = ($urandom_range(0, 7) == 0);
      bus.load_val    = W'($urandom);
      bus.en          = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) bus.up_dn = ~bus.up_dn;
      bus.gray_in     = W'($urandom);
      bus.gray_in_vld = $urandom_range(0, 1) == 1;
      tick();
    end

    rst = 1'b0; bus.en = 1'b0; bus.load = 1'b0; bus.gray_in_vld = 1'b0;
    tick(); tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 The block SHALL have one parameter `WIDTH`, default 4, giving the counter and decoder width in bits; legal range 2..32.
REQ-002 The ports SHALL be, in order:
- `clk` input, 1 bit: the single clock; all state updates on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `en` input, 1 bit: count enable.
- `up_dn` input, 1 bit: 1 = count up, 0 = count down.
- `load` input, 1 bit: parallel load strobe.
- `load_val` input, `WIDTH` bits: binary load value.
- `bin_out` output, `WIDTH` bits: registered binary count.
- `gray_out` output, `WIDTH` bits: registered Gray code of the count.
- `tc` output, 1 bit: combinational terminal count.
- `wrap` output, 1 bit: registered one-cycle wrap pulse.
- `gray_in` input, `WIDTH` bits: Gray word to decode.
- `gray_in_vld` input, 1 bit: `gray_in` is valid this cycle.
- `bin_dec` output, `WIDTH` bits: registered decoded binary.
- `bin_dec_vld` output, 1 bit: `bin_dec` is valid.

Function
REQ-003 Update priority SHALL be: `rst` first, then `load`, then `en`; with none asserted, all counter state holds.
REQ-004 On a `load` cycle, `bin_out` SHALL become `load_val` and `gray_out` SHALL become bin2gray(`load_val`) on the next edge, regardless of `en` and `up_dn`.
REQ-005 With `en`=1 and `load`=0, `bin_out` SHALL step by +1 when `up_dn`=1 and by -1 when `up_dn`=0, modulo 2^`WIDTH`, with latency 1 cycle.
REQ-006 `gray_out` SHALL equal bin2gray(`bin_out`) = `bin_out` ^ (`bin_out` >> 1) every cycle, and SHALL change in exactly one bit per counting step, including the wrap step.
REQ-007 `tc` SHALL be 1 when (`up_dn`=1 and `bin_out` = all ones) or (`up_dn`=0 and `bin_out` = 0); it is independent of `en`.
REQ-008 `wrap` SHALL be 1 for exactly the one cycle after an edge where `en`=1, `load`=0 and `tc`=1; otherwise it SHALL be 0.
REQ-009 A direction change SHALL take effect on the same cycle it is applied, with no lost or extra step.
REQ-010 The decoder SHALL register `bin_dec` = gray2bin(`gray_in`), where bit i is the XOR of `gray_in` bits `WIDTH`-1 down to i, with latency 1 cycle.
REQ-011 `bin_dec_vld` SHALL equal `gray_in_vld` delayed by one cycle.
REQ-012 `bin_dec` SHALL hold its value while `gray_in_vld`=0.
REQ-013 The decoder SHALL accept back-to-back valid words, one per cycle, with no stall.
REQ-014 The decoder SHALL be fully independent of the counter path.

Reset
REQ-015 While `rst`=1, `bin_out`, `gray_out`, `wrap`, `bin_dec` and `bin_dec_vld` SHALL all be 0 at the next edge.
REQ-016 Reset SHALL override a simultaneous `load`, `en` or `gray_in_vld`.
REQ-017 `tc` SHALL follow REQ-007 from the reset value, so it is 1 after reset when `up_dn`=0.
REQ-018 Reset asserted mid-count SHALL discard the count, and counting SHALL resume from 0 on the first cycle after `rst` deasserts.

Configuration
REQ-019 The macro `GRAY_CNT_SAT_EN` SHALL select terminal-count behaviour.
- Defined: with `en`=1 and `tc`=1, the count SHALL hold at all ones (up) or 0 (down), and `wrap` SHALL stay 0; `load` still operates.
- Undefined: the counter SHALL wrap modulo 2^`WIDTH` per REQ-005 and REQ-008.

Structure
REQ-020 A shared package `gray_pkg` SHALL hold:
- the functions bin2gray and gray2bin, parameterised by width;
- the constant `GRAY_DEFAULT_WIDTH` = 4.
REQ-021 The decoder path SHALL be a sub-module `gray2bin_reg` (parameter `WIDTH`; ports `clk`, `rst`, `gray_in`, `gray_in_vld`, `bin_dec`, `bin_dec_vld`), instantiated once.

Verification (`WIDTH`=4)
REQ-022 Reset, then `en`=1, `up_dn`=1 for 3 cycles -> `bin_out`=3, `gray_out`=0010, `wrap`=0.
REQ-023 Without `GRAY_CNT_SAT_EN`: from `bin_out`=15 (`tc`=1), `en` up for 1 cycle -> `bin_out`=0, `gray_out`=0000, `wrap`=1 for exactly 1 cycle.
REQ-024 From reset, `up_dn`=0 and `en`=1 for 1 cycle -> `bin_out`=15, `gray_out`=1000, `wrap`=1.
REQ-025 `load`=1, `load_val`=9, `en`=1 in the same cycle -> `bin_out`=9, `gray_out`=1101, with no increment applied.
REQ-026 `gray_in`=1101, 1000, 0010 on consecutive cycles with `gray_in_vld`=1 -> one cycle later `bin_dec`=9, 15, 3 with `bin_dec_vld`=1; `rst` asserted mid-stream -> `bin_dec_vld`=0 on the next cycle.
REQ-027 With `GRAY_CNT_SAT_EN`: at `bin_out`=15, `en` up for 5 cycles -> `bin_out` stays 15 and `wrap` stays 0.
REQ-028 Every directed run SHALL check that consecutive `gray_out` values differ by Hamming distance 1 whenever the count steps.
